// File: rtl/ysyx_22041412_csr_pkg.sv
// ysyx_22041412_csr_pkg: CSR addresses, op encodings, bit positions, cause codes and FSM states
package ysyx_22041412_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] SYS_ECALL    = 12'h000;
  localparam logic [11:0] SYS_MRET     = 12'h302;
  localparam logic [2:0] OP_SYS = 3'b000;
  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;
  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP    = 11;
  localparam int MIE_MTIE  = 7;
  localparam logic [63:0] MSTATUS_WMASK = 64'h1888;
  localparam logic [63:0] MIE_WMASK     = 64'h80;
  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_MTI     = 7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_EXEC = ST_EXEC, S_RESP = ST_RESP} state_e;
endpackage

// File: rtl/ysyx_22041412_csr_if.sv
// ysyx_22041412_csr_if: execute-stage to CSR unit request/response handshake
interface ysyx_22041412_csr_if #(parameter int XLEN = 64);
  logic            valid_i;
  logic [2:0]      op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            src_zero_i;
  logic [XLEN-1:0] pc_i;
  logic            timer_irq_i;
  logic            ready_o;
  logic [XLEN-1:0] rdata_o;
  logic            redirect_o;
  logic            illegal_o;
  logic            irq_pending_o;
  modport master (
    output valid_i, op_i, csr_addr_i, wdata_i, src_zero_i, pc_i, timer_irq_i,
    input  ready_o, rdata_o, redirect_o, illegal_o, irq_pending_o
  );
  modport slave (
    input  valid_i, op_i, csr_addr_i, wdata_i, src_zero_i, pc_i, timer_irq_i,
    output ready_o, rdata_o, redirect_o, illegal_o, irq_pending_o
  );
endinterface

// File: rtl/ysyx_22041412_csr_alu.sv
// ysyx_22041412_csr_alu: new CSR value from op/old/wdata with per-CSR write mask
module ysyx_22041412_csr_alu
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      i_op,
  input  logic [11:0]     i_addr,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_new
);
  logic [XLEN-1:0] w_raw, w_mask;
  // op low bits select write/set/clear; masked-off bits keep their old value
  always_comb begin
    w_raw  = i_op == 2'b01 ? i_wdata : i_op == 2'b10 ? i_old | i_wdata : i_old & ~i_wdata;
    w_mask = i_addr == CSR_MSTATUS ? XLEN'(MSTATUS_WMASK) :
             i_addr == CSR_MIE     ? XLEN'(MIE_WMASK) :
             i_addr == CSR_MTVEC   ? ~XLEN'(3) :
             i_addr == CSR_MEPC    ? ~XLEN'(1) : {XLEN{1'b1}};
    o_new  = (w_raw & w_mask) | (i_old & ~w_mask);
  end
endmodule

// File: rtl/ysyx_22041412_csr_unit.sv
// ysyx_22041412_csr_unit: M-mode CSR file with trap sequencing; define YSYX_22041412_CSR_MCYCLE_EN for mcycle at 0xB00
module ysyx_22041412_csr_unit
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'ha00001800,
  parameter logic [63:0] HART_ID     = 64'd0
) (
  input logic                clk,
  input logic                rst,
  ysyx_22041412_csr_if.slave bus
);
  state_e          r_state;
  logic [2:0]      r_op;
  logic [11:0]     r_addr;
  logic [XLEN-1:0] r_wdata, r_pc, r_new, r_rdata;
  logic            r_src_zero, r_irq, r_we, r_trap, r_mret;
  logic            r_ready, r_redirect, r_illegal, r_irq_pending;
  logic [XLEN-1:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [XLEN-1:0] w_old, w_new, w_mip;
  logic            w_known, w_csr_op, w_wr, w_ro, w_ecall, w_mret, w_illegal;
`ifdef YSYX_22041412_CSR_MCYCLE_EN
  logic [XLEN-1:0] r_mcycle;
`endif
  assign w_mip     = XLEN'({bus.timer_irq_i, 7'd0});
  assign w_csr_op  = r_op[1:0] != 2'b00;
  assign w_wr      = r_op[1:0] == 2'b01 || !r_src_zero;
  assign w_ro      = r_addr[11:10] == 2'b11 || r_addr == CSR_MIP;
  assign w_ecall   = r_op == OP_SYS && r_addr == SYS_ECALL;
  assign w_mret    = r_op == OP_SYS && r_addr == SYS_MRET;
  assign w_illegal = !r_irq && (w_csr_op ? !w_known || (w_wr && w_ro) : !(w_ecall || w_mret));
  assign bus.ready_o       = r_ready;
  assign bus.rdata_o       = r_rdata;
  assign bus.redirect_o    = r_redirect;
  assign bus.illegal_o     = r_illegal;
  assign bus.irq_pending_o = r_irq_pending;
  ysyx_22041412_csr_alu #(.XLEN(XLEN)) u_alu (
    .i_op    (r_op[1:0]),
    .i_addr  (r_addr),
    .i_old   (w_old),
    .i_wdata (r_wdata),
    .o_new   (w_new)
  );
  // address decode: old value of the captured CSR and whether it exists
  always_comb begin
    w_known = 1'b1;
    w_old   = '0;
    case (r_addr)
      CSR_MSTATUS:  w_old = r_mstatus;
      CSR_MIE:      w_old = r_mie;
      CSR_MTVEC:    w_old = r_mtvec;
      CSR_MSCRATCH: w_old = r_mscratch;
      CSR_MEPC:     w_old = r_mepc;
      CSR_MCAUSE:   w_old = r_mcause;
      CSR_MIP:      w_old = w_mip;
      CSR_MHARTID:  w_old = XLEN'(HART_ID);
`ifdef YSYX_22041412_CSR_MCYCLE_EN
      CSR_MCYCLE:   w_old = r_mcycle;
`endif
      default:      w_known = 1'b0;
    endcase
  end
  // IDLE -> EXEC -> RESP sequencing; the response is registered at the end of EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_pc          <= '0;
      r_src_zero    <= 1'b0;
      r_irq         <= 1'b0;
      r_new         <= '0;
      r_we          <= 1'b0;
      r_trap        <= 1'b0;
      r_mret        <= 1'b0;
      r_rdata       <= '0;
      r_ready       <= 1'b0;
      r_redirect    <= 1'b0;
      r_illegal     <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.valid_i) begin
          r_state    <= S_EXEC;
          r_op       <= bus.op_i;
          r_addr     <= bus.csr_addr_i;
          r_wdata    <= bus.wdata_i;
          r_pc       <= bus.pc_i;
          r_src_zero <= bus.src_zero_i;
          r_irq      <= r_irq_pending;
        end
        S_EXEC: begin
          r_state    <= S_RESP;
          r_ready    <= 1'b1;
          r_redirect <= r_irq || w_ecall || w_mret;
          r_illegal  <= w_illegal;
          r_rdata    <= r_irq || w_ecall ? r_mtvec : w_illegal ? '0 : w_mret ? r_mepc : w_old;
          r_new      <= w_new;
          r_we       <= !r_irq && w_csr_op && w_wr && !w_illegal;
          r_trap     <= r_irq || w_ecall;
          r_mret     <= !r_irq && w_mret;
        end
        default: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b0;
          r_redirect <= 1'b0;
          r_illegal  <= 1'b0;
        end
      endcase
      r_irq_pending <= r_mstatus[MS_MIE] & r_mie[MIE_MTIE] & bus.timer_irq_i;
    end
  end
  // CSR state commits on the edge that ends RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mstatus  <= XLEN'(MSTATUS_RST);
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (r_state == S_RESP) begin
      if (r_we) begin
        case (r_addr)
          CSR_MSTATUS:  r_mstatus  <= r_new;
          CSR_MIE:      r_mie      <= r_new;
          CSR_MTVEC:    r_mtvec    <= r_new;
          CSR_MSCRATCH: r_mscratch <= r_new;
          CSR_MEPC:     r_mepc     <= r_new;
          CSR_MCAUSE:   r_mcause   <= r_new;
          default: ;
        endcase
      end
      if (r_trap) begin
        r_mepc                     <= r_pc & ~XLEN'(1);
        r_mcause                   <= r_irq ? {1'b1, (XLEN-1)'(CAUSE_MTI)} : XLEN'(CAUSE_ECALL_M);
        r_mstatus[MS_MPIE]         <= r_mstatus[MS_MIE];
        r_mstatus[MS_MIE]          <= 1'b0;
        r_mstatus[MS_MPP+1:MS_MPP] <= 2'b11;
      end
      if (r_mret) begin
        r_mstatus[MS_MIE]  <= r_mstatus[MS_MPIE];
        r_mstatus[MS_MPIE] <= 1'b1;
      end
    end
  end
`ifdef YSYX_22041412_CSR_MCYCLE_EN
  // free-running cycle counter; a committed write wins over the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mcycle <= '0;
    else r_mcycle <= r_state == S_RESP && r_we && r_addr == CSR_MCYCLE ? r_new : r_mcycle + 1'b1;
  end
`endif
endmodule

// File: doc/ysyx_22041412_csr_unit.md
# ysyx_22041412_csr_unit

Parametrised machine-mode CSR unit for the NPC core. It replaces the fixed six-entry CSR file with full 12-bit CSR address decode and CSRRW/S/C (register and immediate) semantics. It also handles ECALL/MRET trap sequencing, timer-interrupt entry, illegal-access reporting and an optional cycle counter. The unit sits beside the execute stage and talks to it over a valid/ready handshake.

## Interface
- XLEN, 64, datapath width; 32 or 64
- MSTATUS_RST, 64'ha00001800, mstatus reset value, truncated to XLEN
- HART_ID, 0, value read from mhartid
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- valid_i  in  1  request valid; held until ready_o
- op_i  in  3  000 SYSTEM, 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr_i  in  12  CSR address; for SYSTEM: 0x000 ECALL, 0x302 MRET
- wdata_i  in  XLEN  rs1 value or zero-extended uimm, supplied by the caller
- src_zero_i  in  1  rs1 index / uimm is zero; suppresses the write for RS/RC/RSI/RCI
- pc_i  in  XLEN  PC of the requesting instruction
- timer_irq_i  in  1  level-sensitive machine timer interrupt (MTIP)
- ready_o  out  1  one-cycle completion pulse
- rdata_o  out  XLEN  old CSR value, or redirect target when redirect_o=1
- redirect_o  out  1  qualified by ready_o; the core must jump to rdata_o
- illegal_o  out  1  qualified by ready_o; illegal access, no state changed
- irq_pending_o  out  1  registered: mstatus.MIE & mie.MTIE & timer_irq_i

## Operation
- FSM states and transitions:
  - IDLE: on valid_i, capture op/addr/wdata/pc/src_zero, go to EXEC.
  - EXEC: read the old value and compute the new one; go to RESP.
  - RESP: commit the write, assert ready_o, go to IDLE.
- Implemented CSRs and addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only, bit7=timer_irq_i), mhartid 0xF14 (read-only).
- New value: RW/RWI → wdata; RS/RSI → old|wdata; RC/RCI → old&~wdata.
- Set/clear with src_zero_i=1 performs no write, so it is a legal read of a read-only CSR.
- Write masks:
  - mtvec[1:0] and mepc[0] always read 0 (direct mode only).
  - mstatus writable bits are MIE(3), MPIE(7), MPP(12:11).
  - mie writable bit is MTIE(7).
- Illegal accesses: an unimplemented address, or a write to a read-only CSR (addr[11:10]==11 or mip). Response is illegal_o=1, rdata_o=0, no state change.
- ECALL: mepc←pc_i, mcause←11, trap entry; rdata_o=mtvec, redirect_o=1.
- MRET: MIE←MPIE, MPIE←1; rdata_o=mepc, redirect_o=1.
- Any other SYSTEM address is illegal.
- Trap entry: MPIE←MIE, MIE←0, MPP←2'b11.
- Interrupt priority: if irq_pending_o=1 when IDLE accepts valid_i, the request is not executed. Instead mepc←pc_i and mcause←{1'b1,(XLEN-1)'d7}, trap entry is applied, rdata_o=mtvec, redirect_o=1. The core re-issues the instruction after the handler.

## Timing
- Latency: valid_i sampled high at edge N → ready_o high during cycle N+2 for exactly one cycle.
- All CSR updates become visible at the edge ending the RESP cycle.
- The caller deasserts valid_i in the cycle after ready_o. valid_i still high in IDLE starts a new request.
- Reset values: ready_o, redirect_o, illegal_o, irq_pending_o = 0; rdata_o = 0; FSM = IDLE; mstatus = MSTATUS_RST; all other CSRs = 0.
- Reset mid-operation aborts the request with no CSR write and no ready_o.
- irq_pending_o updates every cycle, independent of FSM state.

## Configuration
- YSYX_22041412_CSR_MCYCLE_EN defined: mcycle at 0xB00 is XLEN wide and increments every cycle, wrapping to 0. A CSR write in the RESP cycle takes priority over the increment in that cycle.
- Not defined: 0xB00 is unimplemented, so any access is illegal.

## Structure
- Package ysyx_22041412_csr_pkg holds:
  - CSR address constants
  - op_i encodings
  - mstatus/mie bit positions
  - cause codes (ECALL_M=11, MTI=7)
  - FSM state enum
- Sub-module ysyx_22041412_csr_alu is combinational. It computes the new value from op, old and wdata, and applies the per-CSR write mask.

## Test plan
- After reset, RS 0x300 with src_zero_i=1 → ready_o at N+2, rdata_o=0xa00001800, illegal_o=0.
- RW 0x305 wdata=0x80000103, then RS 0x305 src_zero → rdata_o=0x80000100.
- ECALL at pc_i=0x80000040 with mtvec=0x80000100 → redirect_o=1, rdata_o=0x80000100, mepc=0x80000040, mcause=11, MIE=0. A following MRET → rdata_o=0x80000040.
- mstatus.MIE=1, mie=0x80, timer_irq_i=1, then valid_i RW 0x340 → mscratch unchanged, mcause=0x8000000000000007, redirect_o=1.
- RW 0xF14 wdata=1 → illegal_o=1, rdata_o=0. Access 0x7C0 → illegal_o=1.
- With MCYCLE_EN, RW 0xB00 wdata=0xFFFFFFFFFFFFFFFF → wraps to 0 one cycle after the write, then counts up. Reset asserted during EXEC → no ready_o, mcycle=0.
